// File: rtl/tic_tac_toe_nxn_game.sv
`default_nettype none
// ============================================================================
// tic_tac_toe_nxn_game : N x N player-vs-computer game controller, WIN_LEN rule
// Revision 1.0
// ============================================================================
module tic_tac_toe_nxn_game #(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  localparam int CELLS  = N * N,
  localparam int POS_W  = $clog2(CELLS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic               play,
  input  logic               pc,
  input  logic [POS_W-1:0]   player_position,
  input  logic [POS_W-1:0]   computer_position,
  output logic [2*CELLS-1:0] board,
  output logic [1:0]         who,
  output logic               turn,
  output logic               illegal,
  output logic               busy
);

  localparam int CNT_W = $clog2(CELLS + 1);
  localparam int RC_W  = $clog2(N);

  typedef enum logic [2:0] {
    WAIT_P = 3'd0,
    WAIT_C = 3'd1,
    CHK0   = 3'd2,
    CHK1   = 3'd3,
    CHK2   = 3'd4,
    CHK3   = 3'd5,
    OVER   = 3'd6
  } state_t;

  state_t             state, state_n;
  logic [2*CELLS-1:0] board_n;
  logic [1:0]         who_n;
  logic               turn_n, illegal_n;
  logic [CNT_W-1:0]   move_cnt, move_cnt_n;
  logic [RC_W-1:0]    last_row, last_row_n, last_col, last_col_n;
  logic [1:0]         owner, owner_n;
  logic               hit, hit_n;
  logic               play_q, pc_q;

  logic               req;
  logic [POS_W-1:0]   req_pos;
  logic [1:0]         mover;
  logic [CELLS-1:0]   pos_match, cell_empty, own_cell;
  logic [2*CELLS-1:0] cell_wr;
  logic               cell_free;
  logic               line_hit;

  assign req     = (state == WAIT_P) ? (play & ~play_q) :
                   (state == WAIT_C) ? (pc & ~pc_q) : 1'b0;
  assign req_pos = (state == WAIT_P) ? player_position : computer_position;
  assign mover   = (state == WAIT_P) ? 2'b01 : 2'b10;

  generate
    for (genvar i = 0; i < CELLS; i++) begin : g_cell
      assign pos_match[i]      = (req_pos == POS_W'(i));
      assign cell_empty[i]     = (board[2*i +: 2] == 2'b00);
      assign own_cell[i]       = (board[2*i +: 2] == owner);
      assign cell_wr[2*i +: 2] = pos_match[i] ? mover : 2'b00;
    end
  endgenerate

  // Positions >= N*N match no cell, so they are never free and get rejected.
  assign cell_free = |(pos_match & cell_empty);
  assign busy      = (state == CHK0) || (state == CHK1) || (state == CHK2) || (state == CHK3);

  function automatic logic owns(input logic [CELLS-1:0] v, input int r, input int c);
    logic [CELLS-1:0] t;
    t = v >> (r * N + c);
    return (r >= 0) && (r < N) && (c >= 0) && (c < N) && t[0];
  endfunction

  // Run length through the last move along the direction checked this cycle.
  always_comb begin
    int   dr, dc, cnt;
    logic fwd, bwd;
    dr = 1;
    dc = 0;
    case (state)
      CHK0:    begin dr = 0; dc = 1; end
      CHK2:    dc = 1;
      CHK3:    dc = -1;
      default: ;
    endcase
    cnt = 1;
    fwd = 1'b1;
    bwd = 1'b1;
    for (int s = 1; s < WIN_LEN; s++) begin
      fwd = fwd && owns(own_cell, int'(last_row) + s * dr, int'(last_col) + s * dc);
      bwd = bwd && owns(own_cell, int'(last_row) - s * dr, int'(last_col) - s * dc);
      cnt = cnt + int'(fwd) + int'(bwd);
    end
    line_hit = (cnt >= WIN_LEN);
  end

  always_comb begin
    state_n    = state;
    board_n    = board;
    who_n      = who;
    turn_n     = turn;
    illegal_n  = 1'b0;
    move_cnt_n = move_cnt;
    last_row_n = last_row;
    last_col_n = last_col;
    owner_n    = owner;
    hit_n      = hit;
    if (new_game) begin
      state_n    = WAIT_P;
      board_n    = '0;
      who_n      = 2'b00;
      turn_n     = 1'b0;
      move_cnt_n = '0;
      last_row_n = '0;
      last_col_n = '0;
      owner_n    = 2'b00;
      hit_n      = 1'b0;
    end else begin
      case (state)
        WAIT_P, WAIT_C: begin
          if (req) begin
            if (cell_free) begin
              board_n    = board | cell_wr;
              last_row_n = RC_W'(int'(req_pos) / N);
              last_col_n = RC_W'(int'(req_pos) % N);
              move_cnt_n = move_cnt + CNT_W'(1);
              owner_n    = mover;
              hit_n      = 1'b0;
              state_n    = CHK0;
            end else begin
              illegal_n = 1'b1;
            end
          end
        end
        CHK0: begin hit_n = hit | line_hit; state_n = CHK1; end
        CHK1: begin hit_n = hit | line_hit; state_n = CHK2; end
        CHK2: begin hit_n = hit | line_hit; state_n = CHK3; end
        CHK3: begin
          if (hit || line_hit) begin
            who_n   = owner;
            state_n = OVER;
          end else if (move_cnt == CNT_W'(CELLS)) begin
            who_n   = 2'b11;
            state_n = OVER;
          end else begin
            turn_n  = ~turn;
            state_n = (owner == 2'b01) ? WAIT_C : WAIT_P;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= WAIT_P;
      board    <= '0;
      who      <= 2'b00;
      turn     <= 1'b0;
      illegal  <= 1'b0;
      move_cnt <= '0;
      last_row <= '0;
      last_col <= '0;
      owner    <= 2'b00;
      hit      <= 1'b0;
      play_q   <= 1'b0;
      pc_q     <= 1'b0;
    end else begin
      state    <= state_n;
      board    <= board_n;
      who      <= who_n;
      turn     <= turn_n;
      illegal  <= illegal_n;
      move_cnt <= move_cnt_n;
      last_row <= last_row_n;
      last_col <= last_col_n;
      owner    <= owner_n;
      hit      <= hit_n;
      play_q   <= new_game ? 1'b0 : play;
      pc_q     <= new_game ? 1'b0 : pc;
    end
  end

endmodule
`default_nettype wire
